// File: rtl/hamming_pkg.sv
// Shared constants, position mapping and encoder state for the serial
// Hamming SEC link: 128 data bits plus 8 parity bits at positions 2^i.
package hamming_pkg;

    localparam int DATA_W = 128;
    localparam int CODE_W = 136;
    localparam int PAR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_SOF,
        ST_SEND,
        ST_GAP
    } enc_state_e;

    function automatic logic is_par_pos(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data index carried at non-parity position p: skip the powers of two at or below p.
    function automatic int data_idx(input int p);
        return p - $clog2(p + 1);
    endfunction

    function automatic int par_idx(input int p);
        return $clog2(p);
    endfunction

    function automatic logic [CODE_W:1] par_mask(input int i);
        logic [CODE_W:1] m;
        m = '0;
        for (int p = 1; p <= CODE_W; p++) begin
            m[p] = !is_par_pos(p) && (((p >> i) & 1) != 0);
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_encoder_if.sv
// Parallel-load / serial-out bundle between a word source and the encoder.
// Fault-injection signals exist only when ENC_ERR_INJECT_EN is defined.
interface hamming_encoder_if;
    import hamming_pkg::*;

    logic              start;
    logic [DATA_W:1]   din;
    logic              busy;
    logic              frame_start;
    logic              serial_out;
    logic              done;
`ifdef ENC_ERR_INJECT_EN
    logic              err_en;
    logic [7:0]        err_pos;
`endif

    modport master (
        output start,
        output din,
`ifdef ENC_ERR_INJECT_EN
        output err_en,
        output err_pos,
`endif
        input  busy,
        input  frame_start,
        input  serial_out,
        input  done
    );

    modport slave (
        input  start,
        input  din,
`ifdef ENC_ERR_INJECT_EN
        input  err_en,
        input  err_pos,
`endif
        output busy,
        output frame_start,
        output serial_out,
        output done
    );

endinterface

// File: rtl/hamming_parity_gen.sv
// Combinational 128-bit data to 136-bit even-parity Hamming codeword.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W:1] i_data,
    output logic [CODE_W:1] o_code
);

    logic [CODE_W:1] w_place;

    for (genvar p = 1; p <= CODE_W; p++) begin : g_pos
        if (is_par_pos(p)) begin : g_par
            assign w_place[p] = 1'b0;
            assign o_code[p]  = ^(w_place & par_mask(par_idx(p)));
        end else begin : g_dat
            assign w_place[p] = i_data[data_idx(p)];
            assign o_code[p]  = w_place[p];
        end
    end

endmodule

// File: rtl/hamming_encoder.sv
// Serial Hamming SEC encoder: load a word, build the codeword, shift it out
// position 136 first, then hold busy for IFG cycles. Option: ENC_ERR_INJECT_EN.
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int IFG = 8
) (
    input  logic              clk,
    input  logic              reset,
    hamming_encoder_if.slave  bus
);

    enc_state_e       r_state;
    enc_state_e       w_state;
    logic [DATA_W:1]  r_data;
    logic [CODE_W:1]  r_code;
    logic [CODE_W:1]  w_code;
    logic [CODE_W:1]  w_mask;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt;
    logic [7:0]       r_gap;
    logic [7:0]       w_gap;
    logic             r_busy;
    logic             w_busy;
    logic             r_fs;
    logic             w_fs;
    logic             r_ser;
    logic             w_ser;
    logic             r_done;
    logic             w_done;
    logic             w_load;
    logic             w_build;

    hamming_parity_gen u_parity (
        .i_data (r_data),
        .o_code (w_code)
    );

`ifdef ENC_ERR_INJECT_EN
    logic             r_err_en;
    logic [7:0]       r_err_pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_en  <= 1'b0;
            r_err_pos <= '0;
        end else if (w_load) begin
            r_err_en  <= bus.err_en;
            r_err_pos <= bus.err_pos;
        end
    end

    // Out-of-range positions leave the codeword untouched.
    always_comb begin
        w_mask = '0;
        if (r_err_en && (r_err_pos >= 8'd1) && (r_err_pos <= 8'(CODE_W)))
            w_mask[r_err_pos] = 1'b1;
    end
`else
    assign w_mask = '0;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_busy  = r_busy;
        w_fs    = 1'b0;
        w_ser   = 1'b0;
        w_done  = 1'b0;
        w_load  = 1'b0;
        w_build = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load  = 1'b1;
                    w_busy  = 1'b1;
                    w_state = ST_BUILD;
                end
            end
            ST_BUILD: begin
                w_build = 1'b1;
                w_cnt   = 8'(CODE_W);
                w_fs    = 1'b1;
                w_state = ST_SOF;
            end
            ST_SOF: begin
                w_ser   = r_code[r_cnt];
                w_state = ST_SEND;
            end
            ST_SEND: begin
                // r_cnt is the position currently on the line.
                if (r_cnt == 8'd1) begin
                    w_done = 1'b1;
                    if (IFG == 0) begin
                        w_busy  = 1'b0;
                        w_state = ST_IDLE;
                    end else begin
                        w_gap   = 8'(IFG - 1);
                        w_state = ST_GAP;
                    end
                end else begin
                    w_cnt = r_cnt - 8'd1;
                    w_ser = r_code[w_cnt];
                end
            end
            ST_GAP: begin
                if (r_gap == 8'd0) begin
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_gap = r_gap - 8'd1;
                end
            end
            default: begin
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_busy  <= 1'b0;
            r_fs    <= 1'b0;
            r_ser   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_busy  <= w_busy;
            r_fs    <= w_fs;
            r_ser   <= w_ser;
            r_done  <= w_done;
            if (w_load)
                r_data <= bus.din;
            if (w_build)
                r_code <= w_code ^ w_mask;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.frame_start = r_fs;
    assign bus.serial_out  = r_ser;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_hamming_encoder.sv
// Scoreboarded bench for hamming_encoder: frames are predicted from a
// syndrome-arithmetic model and checked bit by bit plus strobe timing.
module tb_hamming_encoder;
    import hamming_pkg::*;

    localparam int IFG   = 8;
    localparam int FRAME = 139 + IFG;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hamming_encoder_if bus();

    hamming_encoder #(.IFG(IFG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [136:1] cw;
        logic [128:1] d;
        int           e;
        int           syn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic       inj_en  = 1'b0;
    logic [7:0] inj_pos = 8'd0;

`ifdef ENC_ERR_INJECT_EN
    assign bus.err_en  = inj_en;
    assign bus.err_pos = inj_pos;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Parity bits are the bits of the XOR of all set data positions.
    function automatic logic [136:1] ref_code(input logic [128:1] d);
        logic [136:1] cw;
        int k;
        int s;
        cw = '0;
        k  = 1;
        s  = 0;
        for (int p = 1; p <= 136; p++) begin
            if ($countones(p) != 1) begin
                cw[p] = d[k];
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        for (int i = 0; i < 8; i++) cw[1 << i] = s[i];
        return cw;
    endfunction

    function automatic int inj_syn();
        if (inj_en && inj_pos >= 8'd1 && inj_pos <= 8'd136) return int'(inj_pos);
        return 0;
    endfunction

    function automatic logic [136:1] exp_code(input logic [128:1] d);
        logic [136:1] cw;
        cw = ref_code(d);
        if (inj_syn() != 0) cw[inj_syn()] = ~cw[inj_syn()];
        return cw;
    endfunction

    function automatic int syndrome(input logic [136:1] cw);
        int s;
        s = 0;
        for (int p = 1; p <= 136; p++) if (cw[p]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [128:1] extract(input logic [136:1] cw);
        logic [128:1] d;
        int k;
        d = '0;
        k = 1;
        for (int p = 1; p <= 136; p++) begin
            if ($countones(p) != 1) begin
                d[k] = cw[p];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [128:1] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input logic [128:1] d, input logic [136:1] cw, input int e);
        exp_t x;
        x.cw  = cw;
        x.d   = d;
        x.e   = e;
        x.syn = inj_syn();
        q.push_back(x);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy && t < 4 * FRAME) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1, required busy=0 within %0d cycles", 4 * FRAME);
        end
    endtask

    task automatic send(input logic [128:1] d, input logic [136:1] cw);
        @(negedge clk);
        wait_idle();
        bus.start = 1'b1;
        bus.din   = d;
        push(d, cw, cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = rnd128();
    endtask

    exp_t         cur;
    logic         act = 1'b0;
    logic         wb  = 1'b0;
    logic [136:1] got;

    always @(negedge clk) begin
        if (!reset) begin
            act = 1'b0;
            wb  = 1'b0;
        end else begin
            if (wb && !bus.busy) begin
                check("busy_fall", 256'(cyc), 256'(cur.e + 138 + IFG));
                wb = 1'b0;
            end
            if (bus.frame_start) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_start: got 1 at cycle %0d, required 0", cyc);
                end else begin
                    cur = q.pop_front();
                    check("fs_time", 256'(cyc), 256'(cur.e + 1));
                    act = 1'b1;
                    got = '0;
                end
            end else if (act) begin
                if (cyc >= cur.e + 2 && cyc <= cur.e + 137) begin
                    got[138 - (cyc - cur.e)] = bus.serial_out;
                end else if (cyc == cur.e + 138) begin
                    check("codeword", 256'(got), 256'(cur.cw));
                    check("done", 256'(bus.done), 256'(1));
                    check("ser_idle", 256'(bus.serial_out), 256'(0));
                    check("syndrome", 256'(syndrome(got)), 256'(cur.syn));
                    if (cur.syn == 0) check("data", 256'(extract(got)), 256'(cur.d));
                    act = 1'b0;
                    wb  = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [136:1] cw_msb;
        logic [128:1] d;
        int           e;
        int           en;
        int           n;
        int           t;

        bus.start = 1'b0;
        bus.din   = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", 256'({bus.busy, bus.frame_start, bus.serial_out, bus.done}), 256'(0));
        reset = 1'b1;

        send(128'h0, 136'h0);
        send(128'h1, 136'h7);
        cw_msb      = '0;
        cw_msb[136] = 1'b1;
        cw_msb[128] = 1'b1;
        cw_msb[8]   = 1'b1;
        send({1'b1, 127'b0}, cw_msb);

        repeat (4) begin
            d = rnd128();
            send(d, exp_code(d));
        end

        d = rnd128();
        send(d, exp_code(d));
        repeat (40) @(negedge clk);
        bus.start = 1'b1;
        bus.din   = rnd128();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        @(negedge clk);
        wait_idle();
        en = cyc + 1;
        n  = 0;
        t  = 0;
        bus.start = 1'b1;
        while (n < 3 && t < 5 * FRAME) begin
            d       = rnd128();
            bus.din = d;
            if (cyc + 1 == en) begin
                push(d, exp_code(d), en);
                n++;
                en += FRAME;
            end
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0;

        d = rnd128();
        send(d, exp_code(d));
        e = cyc;
        while (cyc < e + 51) @(negedge clk);
        check("busy_mid", 256'(bus.busy), 256'(1));
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset", 256'({bus.busy, bus.frame_start, bus.serial_out, bus.done}), 256'(0));
        repeat (3) @(negedge clk);
        q.delete();
        reset = 1'b1;
        d = rnd128();
        send(d, exp_code(d));

`ifdef ENC_ERR_INJECT_EN
        inj_en  = 1'b1;
        inj_pos = 8'd77;
        d       = '1;
        send(d, exp_code(d));
        inj_pos = 8'd0;
        send(d, exp_code(d));
        inj_pos = 8'd200;
        d       = rnd128();
        send(d, exp_code(d));
        inj_en  = 1'b0;
`endif

        t = 0;
        while ((q.size() != 0 || act || wb) && t < 4 * FRAME) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || act || wb) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d frames pending, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_encoder.md
# hamming_encoder

Serial Hamming SEC encoder for the 128-bit link. Accepts a 128-bit parallel word on a start strobe, builds the 136-bit codeword (8 parity bits at positions 1, 2, 4, …, 128), and shifts it out one bit per clock. Its frame strobe and serial stream drive the `start` and `serial_in` inputs of the downstream serial Hamming decoder directly.

## Interface
- `IFG`, default 8: idle cycles enforced after the last codeword bit before a new `start` is accepted. This covers the decoder's check, correct and extract turnaround. Range 0..255.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; honoured only when `busy`=0.
- `din`  in  [128:1]  data word, sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until the IFG gap ends.
- `frame_start`  out  1  one-cycle strobe to the decoder's `start`.
- `serial_out`  out  1  codeword bit stream to the decoder's `serial_in`.
- `done`  out  1  one-cycle pulse after the last bit has been driven.
- `err_en`, `err_pos[7:0]`  in  fault injection; present only with `ENC_ERR_INJECT_EN`.

## Operation
- Codeword positions are 1..136. Parity positions are 2^i, i=0..7; all other positions carry data.
- Data mapping, `din` MSB to LSB:
  - `din[128:121]` → positions 136..129
  - `din[120:58]` → 127..65
  - `din[57:27]` → 63..33
  - `din[26:12]` → 31..17
  - `din[11:5]` → 15..9
  - `din[4:2]` → 7..5
  - `din[1]` → 3
- Parity at position 2^i = XOR of all data positions p (1..136) whose bit i is set. This gives even parity, so the 8-bit syndrome over the full codeword is 0.
- Transmission order: position 136 first, position 1 last. This matches the decoder, which shifts in LSB-first so the first bit received lands at position 136.
- FSM states:
  - IDLE: accepting edge when `start`=1. Register `din`, `busy`←1, go to BUILD.
  - BUILD: register the 136-bit codeword, go to SOF.
  - SOF: `frame_start`=1 for this one cycle, bit counter←136, go to SEND.
  - SEND: `serial_out` = codeword[counter], counter decrements. When counter=1 is driven, go to GAP (or IDLE if IFG=0) with `done`=1.
  - GAP: count IFG cycles, then go to IDLE with `busy`←0.
- `start` outside IDLE is ignored and not queued. `din` changes after the accepting edge have no effect.
- `serial_out`=0 in every state except SEND.
- Counter is 8 bits, holds the position directly, and never wraps below 1.

## Timing
- All outputs are registered. Reset values: `busy`=0, `frame_start`=0, `serial_out`=0, `done`=0, state IDLE.
- Edge numbering: E is the accepting edge.
  - E+1: codeword registered.
  - E+1..E+2: `frame_start` high.
  - E+2..E+3: position 136 driven.
  - E+137..E+138: position 1 driven.
  - E+138..E+139: `done` high.
  - E+138+IFG: `busy` falls.
- Earliest next accepting edge: E+139+IFG.
- The decoder samples `frame_start` at E+2 and the first bit at E+3, so bits are contiguous with no gap.
- Reset asserted mid-frame: all outputs go to reset values immediately and the frame is dropped. The first `start` after release produces a complete, fresh frame.

## Configuration
- `ENC_ERR_INJECT_EN` defined:
  - `err_en` and `err_pos` are sampled with `din` on the accepting edge.
  - If `err_en`=1 and 1 ≤ `err_pos` ≤ 136, the bit at position `err_pos` is inverted as it is serialised. Any other `err_pos` value means no inversion.
  - Used to exercise decoder correction.
- Undefined: the ports and logic are absent and the stream is always the clean codeword.

## Structure
- Shared `hamming_pkg` holds:
  - constants `DATA_W`=128, `CODE_W`=136, `PAR_W`=8
  - the data-position/parity-position mapping function
  - the encoder state enum
  - The decoder uses the same constants.
- Sub-module `hamming_parity_gen`: combinational, 128-bit data in, 136-bit codeword out. It is instantiated in BUILD and is reusable by verification models.

## Test plan
- `din`=0, IFG=8 → `frame_start` at E+1, 136 zero bits, `done` at E+138, `busy` falls at E+146.
- `din`=128'h1 → ones only at serial cycles 134, 135, 136 (positions 3, 2, 1); all others 0.
- `din`={1'b1,127'b0} → ones at serial cycles 1, 9, 129 (positions 136, 128, 8).
- `start` held high continuously → frames accepted every 139+IFG cycles. Mid-frame `start` pulses produce no extra `frame_start`.
- Reset pulled low at serial bit 50 → all outputs 0 asynchronously. After release, `start` with random `din` → full frame whose syndrome is 0 and whose extracted data equals `din`.
- With `ENC_ERR_INJECT_EN`:
  - all-ones `din`, `err_en`=1, `err_pos`=77 → only position 77 differs from the reference model.
  - `err_pos`=0 or 200 → no difference.
